// File: rtl/game_alu_datapath.sv
`default_nettype none
// ============================================================================
// Module      : game_alu_datapath
// Description : Operand register bank with an add/sub/mul/cmp execution unit
//               behind a valid/ready command handshake. Multiply is an
//               iterative shift-add taking WIDTH cycles; the other ops
//               complete on the accepting edge.
// Revision    : 1.0 - initial release
// ============================================================================
module game_alu_datapath #(
  parameter  int WIDTH = 8,
  parameter  int NREGS = 4,
  localparam int RSEL  = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ld_en,
  input  logic [RSEL-1:0]  ld_sel,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op,
  input  logic [RSEL-1:0]  sel_a,
  input  logic [RSEL-1:0]  sel_b,
  input  logic             wb_en,
  input  logic [RSEL-1:0]  wb_sel,
  output logic [WIDTH-1:0] res,
  output logic             res_valid,
  output logic             eq,
  output logic             lt,
  output logic             ovf
);

  localparam logic [1:0] C_OP_ADD = 2'd0;
  localparam logic [1:0] C_OP_SUB = 2'd1;
  localparam logic [1:0] C_OP_MUL = 2'd2;
  localparam logic [1:0] C_OP_CMP = 2'd3;

  // Iteration counter must be able to hold the value WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0]   r_regs [NREGS];

  // Multiply working set, captured at acceptance so later loads cannot disturb it
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_m_eq;
  logic               r_m_lt;
  logic               r_m_wb_en;
  logic [RSEL-1:0]    r_m_wb_sel;

  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic               w_accept;
  logic               w_mul_last;
  logic [2*WIDTH-1:0] w_step_acc;

  logic               w_done;
  logic [WIDTH-1:0]   w_res;
  logic               w_ovf;
  logic               w_eq;
  logic               w_lt;
  logic               w_wb;
  logic [RSEL-1:0]    w_wb_tgt;

  assign w_a      = r_regs[sel_a];
  assign w_b      = r_regs[sel_b];
  // Extra MSB of the sum is the carry; of the difference it is the borrow.
  assign w_sum    = {1'b0, w_a} + {1'b0, w_b};
  assign w_diff   = {1'b0, w_a} - {1'b0, w_b};
  assign w_accept = op_valid && op_ready;

  assign w_step_acc = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_last = (r_state == S_MUL) && (r_cnt == CW'(1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and handshake ready
  always_comb begin
    w_state_nxt = r_state;
    op_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid && (op == C_OP_MUL)) begin
          w_state_nxt = S_MUL;
        end
      end
      S_MUL: begin
        if (r_cnt == CW'(1)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Completion mux: either the final multiply step or a single-cycle op
  always_comb begin
    w_done   = 1'b0;
    w_res    = '0;
    w_ovf    = 1'b0;
    w_eq     = 1'b0;
    w_lt     = 1'b0;
    w_wb     = 1'b0;
    w_wb_tgt = '0;
    if (w_mul_last) begin
      w_done   = 1'b1;
      w_res    = w_step_acc[WIDTH-1:0];
      w_ovf    = |w_step_acc[2*WIDTH-1:WIDTH];
      w_eq     = r_m_eq;
      w_lt     = r_m_lt;
      w_wb     = r_m_wb_en;
      w_wb_tgt = r_m_wb_sel;
    end else if (w_accept && (op != C_OP_MUL)) begin
      w_done   = 1'b1;
      w_eq     = (w_a == w_b);
      w_lt     = (w_a < w_b);
      w_wb     = wb_en;
      w_wb_tgt = wb_sel;
      case (op)
        C_OP_ADD: begin
          w_res = w_sum[WIDTH-1:0];
          w_ovf = w_sum[WIDTH];
        end
        C_OP_SUB: begin
          w_res = w_diff[WIDTH-1:0];
          w_ovf = w_diff[WIDTH];
        end
        C_OP_CMP: begin
          w_res = '0;
          w_ovf = 1'b0;
        end
        default: begin
          w_res = '0;
          w_ovf = 1'b0;
        end
      endcase
    end
  end

  // Register bank: load first, writeback afterwards so writeback wins on a clash
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (ld_en) begin
        r_regs[ld_sel] <= data_in;
      end
      if (w_wb) begin
        r_regs[w_wb_tgt] <= w_res;
      end
    end
  end

  // Shift-add multiplier: latch on accept, one partial product per edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_m_eq     <= 1'b0;
      r_m_lt     <= 1'b0;
      r_m_wb_en  <= 1'b0;
      r_m_wb_sel <= '0;
    end else if (w_accept && (op == C_OP_MUL)) begin
      r_mcand    <= {{WIDTH{1'b0}}, w_a};
      r_mplier   <= w_b;
      r_acc      <= '0;
      r_cnt      <= CW'(WIDTH);
      r_m_eq     <= (w_a == w_b);
      r_m_lt     <= (w_a < w_b);
      r_m_wb_en  <= wb_en;
      r_m_wb_sel <= wb_sel;
    end else if (r_state == S_MUL) begin
      r_acc    <= w_step_acc;
      r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      r_cnt    <= r_cnt - CW'(1);
    end
  end

  // Result outputs update only on completion and otherwise hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res       <= '0;
      res_valid <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      res_valid <= w_done;
      if (w_done) begin
        res <= w_res;
        eq  <= w_eq;
        lt  <= w_lt;
        ovf <= w_ovf;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_game_alu_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_alu_datapath
// Description : Self-checking bench for game_alu_datapath. A behavioural
//               model (register array, busy countdown, pending result) is
//               advanced on every rising edge and compared with the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_alu_datapath;

  localparam int     WIDTH = 8;
  localparam int     NREGS = 4;
  localparam int     RSEL  = 2;
  localparam longint MOD   = 64'd1 << WIDTH;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             ld_en;
  logic [RSEL-1:0]  ld_sel;
  logic             op_valid;
  logic             op_ready;
  logic [1:0]       op;
  logic [RSEL-1:0]  sel_a;
  logic [RSEL-1:0]  sel_b;
  logic             wb_en;
  logic [RSEL-1:0]  wb_sel;
  logic [WIDTH-1:0] res;
  logic             res_valid;
  logic             eq;
  logic             lt;
  logic             ovf;

  game_alu_datapath #(.WIDTH(WIDTH), .NREGS(NREGS)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .ld_en     (ld_en),
    .ld_sel    (ld_sel),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op        (op),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .wb_en     (wb_en),
    .wb_sel    (wb_sel),
    .res       (res),
    .res_valid (res_valid),
    .eq        (eq),
    .lt        (lt),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  longint m_regs [NREGS];
  int     m_busy;
  longint p_res;
  bit     p_ovf, p_eq, p_lt, p_wb;
  int     p_wb_sel;
  longint e_res;
  bit     e_valid, e_eq, e_lt, e_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 0;
    m_busy  = 0;
    e_res   = 0;
    e_valid = 0;
    e_eq    = 0;
    e_lt    = 0;
    e_ovf   = 0;
  endtask

  task automatic complete(input longint r, input bit o, input bit q, input bit l,
                          input bit w, input int ws);
    e_valid = 1;
    e_res   = r;
    e_ovf   = o;
    e_eq    = q;
    e_lt    = l;
    if (w) m_regs[ws] = r;
  endtask

  // Advance the model by one rising edge using the inputs present at that edge
  task automatic model_edge();
    longint a, b, r, full;
    bit     o;
    e_valid = 0;
    a = m_regs[sel_a];
    b = m_regs[sel_b];
    if (ld_en) m_regs[ld_sel] = longint'(data_in);
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) complete(p_res, p_ovf, p_eq, p_lt, p_wb, p_wb_sel);
    end else if (op_valid) begin
      case (op)
        2'd0: begin full = a + b; r = full % MOD; o = (full >= MOD); end
        2'd1: begin r = (a - b + MOD) % MOD; o = (a < b); end
        2'd2: begin full = a * b; r = full % MOD; o = (full / MOD) != 0; end
        default: begin r = 0; o = 0; end
      endcase
      if (op == 2'd2) begin
        m_busy   = WIDTH;
        p_res    = r;
        p_ovf    = o;
        p_eq     = (a == b);
        p_lt     = (a < b);
        p_wb     = wb_en;
        p_wb_sel = int'(wb_sel);
      end else begin
        complete(r, o, a == b, a < b, wb_en, int'(wb_sel));
      end
    end
  endtask

  // One clock: model update at the edge, comparison 1 time unit later
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("op_ready",  op_ready,  (m_busy == 0) ? 1 : 0);
    chk("res_valid", res_valid, e_valid);
    chk("res",       res,       e_res);
    chk("eq",        eq,        e_eq);
    chk("lt",        lt,        e_lt);
    chk("ovf",       ovf,       e_ovf);
  endtask

  task automatic quiet();
    ld_en    = 0;
    op_valid = 0;
    wb_en    = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    chk("rst_ready",     op_ready,  1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_outs",      {res, eq, lt, ovf}, 0);
    @(posedge clk);
    #1;
    chk("rst_hold_ready", op_ready,  1);
    chk("rst_hold_valid", res_valid, 0);
    reset = 0;
    model_clear();
  endtask

  task automatic load(input int s, input int v);
    quiet();
    ld_en   = 1;
    ld_sel  = RSEL'(s);
    data_in = WIDTH'(v);
    step();
    ld_en = 0;
  endtask

  task automatic issue(input int o, input int a, input int b, input bit w, input int ws);
    op_valid = 1;
    op       = 2'(o);
    sel_a    = RSEL'(a);
    sel_b    = RSEL'(b);
    wb_en    = w;
    wb_sel   = RSEL'(ws);
    step();
    op_valid = 0;
    wb_en    = 0;
  endtask

  // Run until res_valid, counting cycles with op_ready low; bounded
  task automatic wait_result(output int low);
    int n;
    low = (op_ready == 1'b0) ? 1 : 0;
    n   = 0;
    while (res_valid !== 1'b1 && n < WIDTH + 4) begin
      step();
      if (op_ready == 1'b0) low++;
      n++;
    end
    chk("result_timeout", res_valid, 1);
  endtask

  function automatic logic [WIDTH-1:0] pick_data();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return WIDTH'(1);
      3: return WIDTH'(MOD / 2);
      default: return WIDTH'($urandom_range(0, int'(MOD) - 1));
    endcase
  endfunction

  initial begin
    int low;
    data_in = '0; ld_sel = '0; op = '0; sel_a = '0; sel_b = '0; wb_sel = '0;
    quiet();
    model_clear();
    do_reset();

    // add with carry out
    load(0, 200);
    load(1, 100);
    issue(0, 0, 1, 0, 0);
    chk("add_lit_res", res, 44);
    chk("add_lit_flags", {res_valid, ovf, eq, lt}, 4'b1100);

    // sub with borrow and writeback to r2, then read r2 back
    issue(1, 1, 0, 1, 2);
    chk("sub_lit_res", res, 156);
    chk("sub_lit_flags", {ovf, lt}, 2'b11);
    issue(0, 2, 1, 0, 0);
    chk("add_wb_lit_res", res, 0);
    chk("add_wb_lit_ovf", ovf, 1);

    // multiply without overflow
    load(0, 15);
    load(1, 17);
    issue(2, 0, 1, 0, 0);
    wait_result(low);
    chk("mul_ready_low", low, WIDTH);
    chk("mul_lit_res", res, 255);
    chk("mul_lit_ovf", ovf, 0);

    // multiply with overflow
    load(0, 16);
    issue(2, 0, 1, 0, 0);
    wait_result(low);
    chk("mul2_lit_res", res, 16);
    chk("mul2_lit_ovf", ovf, 1);

    // loads during MUL and a held add request
    op_valid = 1; op = 2'd2; sel_a = 0; sel_b = 1; wb_en = 0;
    step();
    op = 2'd0;
    ld_en = 1; ld_sel = 0; data_in = 3;
    wait_result(low);
    chk("mul3_lit_res", res, 16);
    ld_en = 0;
    step();
    op_valid = 0;
    chk("held_add_valid", res_valid, 1);
    chk("held_add_res", res, 20);

    // same-edge load and writeback to r1: writeback wins
    ld_en = 1; ld_sel = 1; data_in = 99;
    issue(0, 0, 1, 1, 1);
    ld_en = 0;
    chk("wb_clash_res", res, 20);
    issue(0, 1, 0, 0, 0);
    chk("wb_wins_res", res, 23);
    issue(3, 0, 0, 0, 0);
    chk("cmp_lit", {res, eq, lt, ovf}, {8'd0, 3'b100});

    // reset three cycles into a multiply
    issue(2, 0, 1, 0, 0);
    step();
    step();
    do_reset();
    for (int i = 0; i < WIDTH + 2; i++) step();
    issue(0, 0, 1, 0, 0);
    chk("post_rst_add", {res, eq, ovf}, {8'd0, 2'b10});

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        ld_en    = ($urandom_range(0, 2) == 0);
        ld_sel   = RSEL'($urandom_range(0, NREGS - 1));
        data_in  = pick_data();
        op_valid = ($urandom_range(0, 3) != 0);
        op       = 2'($urandom_range(0, 3));
        sel_a    = RSEL'($urandom_range(0, NREGS - 1));
        sel_b    = RSEL'($urandom_range(0, NREGS - 1));
        wb_en    = ($urandom_range(0, 1) == 1);
        wb_sel   = RSEL'($urandom_range(0, NREGS - 1));
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/game_alu_datapath.md
# game_alu_datapath

Parametrised successor to the math-game datapath. It holds a bank of `NREGS` operand registers of `WIDTH` bits and executes add, subtract, multiply and compare on any two of them under a valid/ready command handshake. Multiplication is an iterative shift-add that takes `WIDTH` cycles. It sits between the game controller FSM, which issues loads and ops, and the score/answer checking and hex display logic, which consumes `res`, `eq` and `ovf`.

## Interface
- `WIDTH`, 8: operand/result width in bits (>= 2).
- `NREGS`, 4: number of operand registers (power of 2, >= 2); `RSEL = $clog2(NREGS)`.
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  reset.
  - One clock; reset is asynchronous and active-high.
  - Clears all state immediately.
- `data_in`  in  WIDTH  value for register loads.
- `ld_en`  in  1  load `data_in` into register `ld_sel` at next edge.
- `ld_sel`  in  RSEL  load target register.
- `op_valid`  in  1  command request.
- `op_ready`  out  1  block can accept a command this cycle.
- `op`  in  2  operation select:
  - 0: add.
  - 1: sub.
  - 2: mul.
  - 3: cmp.
- `sel_a`, `sel_b`  in  RSEL  operand register selects.
- `wb_en`  in  1  also write the result back to register `wb_sel`.
- `wb_sel`  in  RSEL  writeback target.
- `res`  out  WIDTH  registered result.
- `res_valid`  out  1  one-cycle pulse: `res`/`eq`/`lt`/`ovf` just updated.
- `eq`  out  1  registered `a == b` of the completed command.
- `lt`  out  1  registered unsigned `a < b` of the completed command.
- `ovf`  out  1  registered overflow of the completed command.

## Operation
- Command accepted on an edge where `op_valid && op_ready`.
  - `op`, `wb_en`, `wb_sel` are sampled on that edge.
  - Operands `a = reg[sel_a]` and `b = reg[sel_b]` are sampled on that edge.
- All arithmetic is unsigned modulo 2^WIDTH:
  - add: `res = a+b`, `ovf` = carry out.
  - sub: `res = a-b` (wraps), `ovf` = borrow (`a < b`).
  - mul: `res` = low WIDTH bits of the 2·WIDTH product, `ovf` = high half nonzero.
  - cmp: `res = 0`, `ovf = 0`; only `eq`/`lt` are meaningful.
- `eq`/`lt` are computed from the sampled operands for every op.
- FSM states: IDLE, MUL.
  - IDLE: `op_ready = 1`.
    - Accepted add/sub/cmp completes at the acceptance edge; stays IDLE.
    - Accepted mul latches operands, clears the 2·WIDTH accumulator, loads the iteration counter with WIDTH, and moves to MUL.
  - MUL: `op_ready = 0`. Each edge performs one shift-add step and decrements the counter. The edge that finishes the last step registers outputs and returns to IDLE.
- Writeback occurs on the completing edge when `wb_en` was sampled high; `reg[wb_sel] <= res` value.
- Loads (`ld_en`) are accepted in any state, including during MUL.
  - A multiply uses its latched operands, so loads during MUL do not disturb it.
- Same edge, same register, load and writeback: writeback wins.
- `op_valid` while `op_ready = 0` is ignored; no queueing. The requester must hold `op_valid`.
- Outputs `res`, `eq`, `lt`, `ovf` hold their values until the next completion.

## Timing
- Reset (async, active-high):
  - All registers, `res`, `eq`, `lt`, `ovf`, `res_valid` = 0.
  - State IDLE, `op_ready = 1` (combinational from state).
- add/sub/cmp latency: accepted at edge k; `res_valid` high during the cycle after edge k.
- mul latency: accepted at edge k; `res_valid` high during the cycle after edge k+WIDTH. `op_ready` is low for exactly WIDTH cycles.
- Back-to-back: a new command can be accepted in the cycle `res_valid` is high, since state is already IDLE. Single-cycle ops therefore sustain one per clock.
- An op reading a register written back on the previous completing edge sees the new value; there is no forwarding hazard.
- Reset asserted mid-MUL:
  - Aborts the op.
  - No `res_valid`, no writeback.
  - All state cleared asynchronously.
- `res_valid` never asserts for two consecutive cycles from one command.

## Test plan
- Reset, load r0=200, r1=100; add a=r0 b=r1 -> after 1 cycle `res_valid`, `res=44`, `ovf=1`, `eq=0`, `lt=0`.
- sub r1-r0 with `wb_en`, `wb_sel=2` -> `res=156`, `ovf=1`, `lt=1`; a subsequent add r2+r1 -> `res=0`, `ovf=1`.
- mul with r0=15, r1=17, WIDTH=8 -> `op_ready` low 8 cycles, then `res=255`, `ovf=0`. With r0=16, r1=17 -> `res=16`, `ovf=1`.
- During mul, load r0=3 every cycle and hold `op_valid` high with an add -> mul result unchanged. The add is accepted in the `res_valid` cycle and completes the next cycle using r0=3.
- Same-edge `ld_en`/`ld_sel=1` with an add completing with `wb_sel=1` -> r1 holds the add result, not `data_in`. cmp on equal regs -> `eq=1`, `res=0`.
- Assert reset 3 cycles into a mul -> `res_valid` never pulses, all outputs 0, `op_ready=1` while reset is high and after release.
